// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// One action per edge, chosen in priority order: flush, then stall (bubble), then load.
module id_ex_latch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_A,
  input  logic [31:0]      in_B,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb,
  input  logic [2:0]       in_m,
  input  logic [3:0]       in_ex,
  output logic [31:0]      out_A,
  output logic [31:0]      out_B,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [1:0]       out_wb,
  output logic [2:0]       out_m,
  output logic [3:0]       out_ex,
  output logic             out_valid,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic ex_is_load;
  logic rt_nonzero;
  logic rt_match;
  logic bubble;

  // A hazard needs a real load in EX writing a non-zero register that the
  // valid decode instruction reads. After the bubble EX holds no load, so a
  // stall never lasts more than one cycle per hazard.
  assign ex_is_load = out_valid & out_m[1];
  assign rt_nonzero = (out_rt != 5'd0);
  assign rt_match   = (out_rt == in_rs) | (out_rt == in_rt);
  assign stall      = in_valid & ex_is_load & rt_nonzero & rt_match;
  assign bubble     = stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_A     <= '0;
      out_B     <= '0;
      out_imm   <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      out_wb    <= '0;
      out_m     <= '0;
      out_ex    <= '0;
      out_valid <= 1'b0;
    end else if (flush || stall) begin
      // Squash or bubble: kill controls, keep data fields as they were.
      out_wb    <= '0;
      out_m     <= '0;
      out_ex    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_A     <= in_A;
      out_B     <= in_B;
      out_imm   <= in_imm;
      out_rs    <= in_rs;
      out_rt    <= in_rt;
      out_rd    <= in_rd;
      out_valid <= in_valid;
      out_wb    <= in_valid ? in_wb : 2'b00;
      out_m     <= in_valid ? in_m  : 3'b000;
      out_ex    <= in_valid ? in_ex : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (bubble && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
